// File: rtl/bnn_layer_one.sv
// First BNN stage: 3x3 XNOR-popcount conv (8 kernels), threshold, 2x2 OR-pool to 8x14x14.
// Optional simulation assertions are compiled in with LAYER_ONE_ASSERT_EN.
package mnist_bnn_pkg;
  typedef enum logic [2:0] {
    s_IDLE,
    s_LAYER_1,
    s_LAYER_2,
    s_LAYER_3,
    s_OUTPUT
  } state_t;
endpackage

module bnn_layer_one
  import mnist_bnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  state_t                    state,
  input  logic [27:0][27:0]         pixels,
  input  logic [7:0][2:0][2:0]      weights,
  output logic [7:0][13:0][13:0]    layer_one_out,
  output logic                      done
);

  typedef enum logic [1:0] {L1_IDLE, L1_RUN, L1_DONE} layerState_t;

  layerState_t             fsm_q, fsm_d;
  logic [3:0]              ro_q, ro_d, co_q, co_d;
  logic                    done_q, done_d;
  logic                    writeEn;
  logic [7:0][13:0][13:0]  out_q;
  logic [7:0]              pool;

  // Thresholded conv result at image pixel (r,c); pixels outside the image read as zero.
  function automatic logic winAct(input logic [27:0][27:0] px, input logic [2:0][2:0] w,
                                  input int r, input int c, input logic odd);
    logic [3:0] cnt;
    logic       p;
    int         rr, cc;
    cnt = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
        p  = 1'b0;
        if (rr >= 0 && rr < 28 && cc >= 0 && cc < 28) p = px[5'(rr)][5'(cc)];
        cnt = cnt + {3'b000, ~(p ^ w[2'(dr)][2'(dc)])};
      end
    end
    return cnt >= (odd ? 4'd6 : 4'd5);
  endfunction

  always_comb begin
    pool = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          pool[3'(k)] = pool[3'(k)] | winAct(pixels, weights[3'(k)],
                                             2 * int'(ro_q) + i, 2 * int'(co_q) + j, k[0]);
        end
      end
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    ro_d    = ro_q;
    co_d    = co_q;
    done_d  = done_q;
    writeEn = 1'b0;
    unique case (fsm_q)
      L1_IDLE: begin
        ro_d   = '0;
        co_d   = '0;
        done_d = 1'b0;
        if (state == s_LAYER_1) fsm_d = L1_RUN;
      end
      L1_RUN: begin
        if (state != s_LAYER_1) begin
          fsm_d  = L1_IDLE;
          ro_d   = '0;
          co_d   = '0;
          done_d = 1'b0;
        end else begin
          writeEn = 1'b1;
          if (co_q == 4'd13) begin
            co_d = '0;
            if (ro_q == 4'd13) begin
              ro_d   = '0;
              fsm_d  = L1_DONE;
              done_d = 1'b1;
            end else begin
              ro_d = ro_q + 4'd1;
            end
          end else begin
            co_d = co_q + 4'd1;
          end
        end
      end
      L1_DONE: begin
        done_d = 1'b1;
        if (state == s_IDLE) begin
          fsm_d  = L1_IDLE;
          done_d = 1'b0;
        end
      end
      default: fsm_d = L1_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= L1_IDLE;
      ro_q   <= '0;
      co_q   <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      ro_q   <= ro_d;
      co_q   <= co_d;
      done_q <= done_d;
      if (writeEn) begin
        for (int k = 0; k < 8; k++) out_q[3'(k)][ro_q][co_q] <= pool[3'(k)];
      end
    end
  end

  assign layer_one_out = out_q;
  assign done          = done_q;

`ifdef LAYER_ONE_ASSERT_EN
  logic                  lastWrite_q, prevRun_q, prevDone_q;
  logic [27:0][27:0]     pixPrev_q;
  logic [7:0][2:0][2:0]  wtsPrev_q;
  logic [7:0]            posCount;

  assign posCount = {4'b0000, ro_q} * 8'd14 + {4'b0000, co_q};

  // Shadow copies let the checks compare against the previous cycle.
  always_ff @(posedge clk) begin
    lastWrite_q <= rst_n && writeEn && ro_q == 4'd13 && co_q == 4'd13;
    prevRun_q   <= rst_n && fsm_q == L1_RUN;
    prevDone_q  <= rst_n && done_q;
    pixPrev_q   <= pixels;
    wtsPrev_q   <= weights;
    if (rst_n) begin
      assert (posCount <= 8'd195) else $error("position counter out of range");
      assert (!(done_q && fsm_q == L1_IDLE)) else $error("done high in IDLE");
      if (done_q && !prevDone_q) assert (lastWrite_q) else $error("done rose early");
      if (fsm_q == L1_RUN && prevRun_q)
        assert (pixels == pixPrev_q && weights == wtsPrev_q)
          else $error("inputs changed during RUN");
    end
  end
`endif

endmodule

// File: tb/tb_bnn_layer_one.sv
// Randomized and directed bench for bnn_layer_one against a whole-image reference model.
module tb_bnn_layer_one;
  import mnist_bnn_pkg::*;

  logic                     clk;
  logic                     rstN;
  state_t                   stateIn;
  logic [27:0][27:0]        pixels;
  logic [7:0][2:0][2:0]     weights;
  logic [7:0][13:0][13:0]   layerOut;
  logic                     done;

  logic [7:0][13:0][13:0]   expOut;
  logic [7:0][13:0][13:0]   oldExp;
  logic [7:0][13:0][13:0]   mixExp;
  int                       testsRun;
  int                       testsFailed;

  bnn_layer_one dut (
    .clk           (clk),
    .rst_n         (rstN),
    .state         (stateIn),
    .pixels        (pixels),
    .weights       (weights),
    .layer_one_out (layerOut),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Conv every image pixel for every kernel, then OR each 2x2 block of activations.
  task automatic buildModel();
    int cnt, rr, cc;
    bit p;
    expOut = '0;
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          cnt = 0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
              rr = r + dr - 1;
              cc = c + dc - 1;
              p = 1'b0;
              if (rr >= 0 && rr < 28 && cc >= 0 && cc < 28) p = pixels[5'(rr)][5'(cc)];
              if (p == weights[3'(k)][2'(dr)][2'(dc)]) cnt++;
            end
          if (cnt >= 5 + (k % 2)) expOut[3'(k)][4'(r / 2)][4'(c / 2)] = 1'b1;
        end
  endtask

  task automatic checkMaps(input string tag, input logic [7:0][13:0][13:0] exp);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("%s_k%0d", tag, k), 256'(layerOut[3'(k)]), 256'(exp[3'(k)]));
  endtask

  task automatic checkAllEqual(input string tag, input logic val);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("%s_k%0d", tag, k), 256'(layerOut[3'(k)]),
                  val ? 256'({196{1'b1}}) : 256'(0));
  endtask

  // Full run: enter layer 1, wait for done, check latency, maps, and the return to idle.
  task automatic applyStimulus(input string tag, input logic [27:0][27:0] px,
                               input logic [7:0][2:0][2:0] wt);
    int edges;
    pixels  = px;
    weights = wt;
    buildModel();
    stateIn = s_LAYER_1;
    edges = 0;
    while (!done && edges < 400) begin
      stepClock();
      edges++;
    end
    checkOutput({tag, "_latency"}, 256'(edges), 256'(197));
    checkMaps(tag, expOut);
    stepClock();
    checkOutput({tag, "_doneHold"}, 256'(done), 256'(1));
    stateIn = s_IDLE;
    stepClock();
    checkOutput({tag, "_doneFall"}, 256'(done), 256'(0));
    checkMaps({tag, "_retain"}, expOut);
  endtask

  function automatic logic [27:0][27:0] randPixels();
    logic [27:0][27:0] px;
    for (int i = 0; i < 28; i++) px[5'(i)] = 28'($urandom());
    return px;
  endfunction

  function automatic logic [7:0][2:0][2:0] randWeights();
    logic [95:0] raw;
    raw = {$urandom(), $urandom(), $urandom()};
    return raw[71:0];
  endfunction

  initial begin
    logic [27:0][27:0]    chkPix;
    logic [7:0][2:0][2:0] chkWts;
    logic [7:0][2:0][2:0] thrWts;
    int                   abortAt, pos;

    testsRun    = 0;
    testsFailed = 0;
    rstN    = 1'b0;
    stateIn = s_IDLE;
    pixels  = '0;
    weights = '0;
    repeat (2) stepClock();
    checkOutput("resetDone", 256'(done), 256'(0));
    checkAllEqual("resetOut", 1'b0);
    rstN = 1'b1;
    stepClock();

    applyStimulus("allZeros", '0, '0);
    checkAllEqual("allZerosConst", 1'b1);
    applyStimulus("allOnes", '1, '1);
    checkAllEqual("allOnesConst", 1'b1);
    applyStimulus("mismatch", '0, '1);
    checkAllEqual("mismatchConst", 1'b0);

    for (int i = 0; i < 28; i++)
      for (int j = 0; j < 28; j++) chkPix[5'(i)][5'(j)] = 1'((i + j) % 2);
    for (int k = 0; k < 8; k++)
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++) chkWts[3'(k)][2'(a)][2'(b)] = 1'((k + a + b) % 2);
    applyStimulus("checker", chkPix, chkWts);
    checkAllEqual("checkerConst", 1'b1);

    thrWts    = randWeights();
    thrWts[0] = 9'b000011111;
    thrWts[1] = 9'b101010101;
    applyStimulus("threshold", '1, thrWts);
    for (int ro = 1; ro < 13; ro++)
      for (int co = 1; co < 13; co++)
        checkOutput($sformatf("thrInterior_%0d_%0d", ro, co),
                    256'({layerOut[0][4'(ro)][4'(co)], layerOut[1][4'(ro)][4'(co)]}),
                    256'(2'b10));

    for (int n = 0; n < 4; n++)
      applyStimulus($sformatf("random%0d", n), randPixels(), randWeights());

    // Abort mid-scan: positions already written hold new values, the rest keep old ones.
    oldExp  = expOut;
    abortAt = int'($urandom_range(20, 150));
    pixels  = randPixels();
    weights = randWeights();
    buildModel();
    stateIn = s_LAYER_1;
    repeat (abortAt + 1) stepClock();
    stateIn = s_LAYER_2;
    repeat (3) stepClock();
    checkOutput("abortDone", 256'(done), 256'(0));
    for (int ro = 0; ro < 14; ro++)
      for (int co = 0; co < 14; co++) begin
        pos = ro * 14 + co;
        for (int k = 0; k < 8; k++)
          mixExp[3'(k)][4'(ro)][4'(co)] = (pos < abortAt) ? expOut[3'(k)][4'(ro)][4'(co)]
                                                          : oldExp[3'(k)][4'(ro)][4'(co)];
      end
    checkMaps("abortPartial", mixExp);
    stateIn = s_IDLE;
    stepClock();

    // Reset in the middle of a run clears everything; a fresh run starts from (0,0).
    pixels  = randPixels();
    weights = randWeights();
    stateIn = s_LAYER_1;
    repeat (101) stepClock();
    rstN = 1'b0;
    stepClock();
    checkOutput("midResetDone", 256'(done), 256'(0));
    checkAllEqual("midResetOut", 1'b0);
    rstN    = 1'b1;
    stateIn = s_IDLE;
    stepClock();
    applyStimulus("afterReset", '0, '0);
    checkAllEqual("afterResetConst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
